ascon_cmd_ctrl: RTL and testbench
=================================

// Module: ascon_cmd_ctrl
// PURPOSE
// Command sequencer in front of ascon_core. Consumes one 32-bit stream of
// instruction (INS) and data (DAT) words and drives the core's
// key/bdi/decrypt/hash interface. Forwards core bdo beats to an output stream
// and latches the tag-verification result. Replaces software/bench
// sequencing of the core.
// PARAMETERS
// LEN_W  24  width of INS byte-length field; byte counter width
// PORTS
// clk             in   1     clock
// rst             in   1     synchronous, active-high reset
// cmd             in   32    INS or DAT word
// cmd_valid       in   1     cmd valid
// cmd_ready       out  1     cmd accepted when cmd_valid&cmd_ready
// key             out  CCSW  key word to core
// key_valid       out  1     key handshake valid
// key_ready       in   1     core key ready
// bdi             out  CCW   block data to core
// bdi_valid       out  1     bdi handshake valid
// bdi_ready       in   1     core bdi ready
// bdi_type        out  4     D_NONCE/D_AD/D_PTCT/D_TAG, D_NULL when idle
// bdi_eot         out  1     last beat of current type
// bdi_eoi         out  1     last beat of whole input
// bdi_valid_bytes out  4     byte-valid mask of bdi
// decrypt         out  1     mode to core, registered
// hash            out  1     mode to core, registered
// bdo/bdo_type/bdo_eot in CCW/4/1  core output beat
// bdo_valid       in   1     core output valid
// bdo_ready       out  1     = out_ready
// out_data        out  CCW   = bdo
// out_type        out  4     = bdo_type
// out_last        out  1     = bdo_eot
// out_valid       out  1     = bdo_valid & bdo_type in {D_PTCT,D_TAG,D_HASH}
// out_ready       in   1     downstream ready
// auth            in   1     core tag result
// auth_valid      in   1     core tag result valid
// auth_ready      out  1     1 in LOAD with op OP_LD_TAG, else 0
// auth_ok         out  1     latched auth on auth_valid&auth_ready
// auth_done       out  1     sticky; set with auth_ok, cleared by next INS
// busy            out  1     state != IDLE
// err             out  1     sticky illegal-op flag; cleared only by rst
// BEHAVIOUR
// - INS fields: op=cmd[31:28], flags=cmd[27:24], len=cmd[LEN_W-1:0] bytes.
// - Reset: state IDLE; decrypt=hash=0; rem=0; err, auth_ok, auth_done=0.
//   All *_valid outputs are 0 in the cycle after rst. rst mid-LOAD/EMPTY
//   aborts the load; no further bdi/key beat is issued.
// - States: IDLE, LOAD, EMPTY.
// - IDLE: cmd_ready=1; all *_valid=0. On accepted INS:
//   - OP_DO_ENC: decrypt=0, hash=0.
//   - OP_DO_DEC: decrypt=1, hash=0.
//   - OP_DO_HASH: decrypt=0, hash=1. All three stay IDLE.
//   - OP_LD_KEY/NONCE/AD/PT/CT/TAG with len>0: op_r=op, eoi_r=flags[0],
//     rem=len, go LOAD.
//   - LD_* with len==0 and flags[0]=1: go EMPTY.
//   - LD_* with len==0 and flags[0]=0: no-op.
//   - Any other op: err=1, stay IDLE.
// - LOAD: each DAT word goes 1:1 to the core, combinationally.
//   - OP_LD_KEY: key=cmd, key_valid=cmd_valid, cmd_ready=key_ready.
//   - Other ops: bdi_valid=cmd_valid, cmd_ready=bdi_ready.
//   - bdi_type: NONCE->D_NONCE, AD->D_AD, PT/CT->D_PTCT, TAG->D_TAG.
//   - Non-last beat (rem>4): bdi=cmd, bdi_valid_bytes=4'hF, eot=eoi=0.
//   - Last beat (rem<=4): bdi=cmd<<((4-rem)*8), eot=1, eoi=eoi_r.
//     bdi_valid_bytes={rem>=4,rem>=3,rem>=2,rem>=1}.
//   - Each handshake: rem = (rem<=4) ? 0 : rem-4. The handshake with rem<=4
//     returns to IDLE in the next cycle.
// - EMPTY: cmd_ready=0; one beat with bdi_valid=1, bdi=0,
//   bdi_valid_bytes=0, eot=eoi=1. bdi_type is D_AD if hash=1, else the
//   type mapped from op_r. Held until bdi_ready, then IDLE. No cmd word is
//   consumed.
// - Output path: bdo_ready=out_ready; a beat transfers on
//   out_valid&out_ready. Runs independently of the state machine; bdo and
//   DAT traffic may transfer in the same cycle.
// - Auth: auth_ok and auth_done are registered when auth_valid&auth_ready.
// - Latency: INS->first core beat 1 cycle. DAT->core 0 cycles (through
//   path). No internal buffering.
// TESTING
// - DO_ENC; LD_KEY len16 (4 DAT) -> key_valid 4 beats, last eot=1, mask F;
//   decrypt=0, hash=0.
// - LD_AD len5 flags0; DAT 11223344,000000AA -> beats 11223344/F, then
//   AA000000/1, eot=1, eoi=0.
// - LD_PT len3 flags1, DAT 00ABCDEF, bdi_ready held 0 for 3 cycles ->
//   cmd_ready=0 while stalled; beat ABCDEF00 mask 7 eot=eoi=1 on release.
// - DO_HASH; LD_AD len0 flags1 -> one beat D_AD, mask 0, eot=eoi=1;
//   hash result beats appear on out_* with out_type D_HASH.
// - DO_DEC; LD_TAG len16, core auth_valid with auth=1 -> auth_ok=1,
//   auth_done=1; next INS clears auth_done.
// - Illegal op 4'hF -> err=1, state IDLE. rst asserted mid LD_PT ->
//   bdi_valid=0 next cycle, busy=0, decrypt=0.

Source files
------------

// File: rtl/ascon_cmd_ctrl.sv
// ascon_cmd_ctrl: command sequencer in front of ascon_core.
// Consumes a single 32-bit stream of instruction (INS) and data (DAT) words,
// drives the core's key/bdi ports and mode bits, forwards core output beats
// downstream and latches the tag-verification result.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd/cmd_valid/cmd_ready       INS/DAT input stream
//   key/key_valid/key_ready       key words to core
//   bdi/bdi_valid/bdi_ready,
//   bdi_type/eot/eoi/valid_bytes  block data to core
//   decrypt, hash                 registered mode bits to core
//   bdo*/bdo_ready                core output beat
//   out_*                         downstream output stream
//   auth/auth_valid/auth_ready    core tag result
//   auth_ok, auth_done            latched tag result, done flag
//   busy, err                     state != IDLE, sticky illegal-op flag
// Opcodes: DO_ENC=0 DO_DEC=1 DO_HASH=2 LD_KEY=3 LD_NONCE=4 LD_AD=5
//          LD_PT=6 LD_CT=7 LD_TAG=8, 9..F illegal.
// Data types: D_NULL=0 D_NONCE=1 D_AD=2 D_PTCT=3 D_TAG=4 D_HASH=5.
module ascon_cmd_ctrl #(
   parameter int unsigned LEN_W = 24,
   parameter int unsigned CCW   = 32,
   parameter int unsigned CCSW  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      cmd,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [CCSW-1:0]  key,
   output logic             key_valid,
   input  logic             key_ready,
   output logic [CCW-1:0]   bdi,
   output logic             bdi_valid,
   input  logic             bdi_ready,
   output logic [3:0]       bdi_type,
   output logic             bdi_eot,
   output logic             bdi_eoi,
   output logic [3:0]       bdi_valid_bytes,
   output logic             decrypt,
   output logic             hash,
   input  logic [CCW-1:0]   bdo,
   input  logic [3:0]       bdo_type,
   input  logic             bdo_eot,
   input  logic             bdo_valid,
   output logic             bdo_ready,
   output logic [CCW-1:0]   out_data,
   output logic [3:0]       out_type,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             auth,
   input  logic             auth_valid,
   output logic             auth_ready,
   output logic             auth_ok,
   output logic             auth_done,
   output logic             busy,
   output logic             err
);

   localparam logic [3:0] OP_DO_ENC   = 4'h0;
   localparam logic [3:0] OP_DO_DEC   = 4'h1;
   localparam logic [3:0] OP_DO_HASH  = 4'h2;
   localparam logic [3:0] OP_LD_KEY   = 4'h3;
   localparam logic [3:0] OP_LD_NONCE = 4'h4;
   localparam logic [3:0] OP_LD_AD    = 4'h5;
   localparam logic [3:0] OP_LD_PT    = 4'h6;
   localparam logic [3:0] OP_LD_CT    = 4'h7;
   localparam logic [3:0] OP_LD_TAG   = 4'h8;

   localparam logic [3:0] D_NULL  = 4'h0;
   localparam logic [3:0] D_NONCE = 4'h1;
   localparam logic [3:0] D_AD    = 4'h2;
   localparam logic [3:0] D_PTCT  = 4'h3;
   localparam logic [3:0] D_TAG   = 4'h4;
   localparam logic [3:0] D_HASH  = 4'h5;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EMPTY = 2'd2} state_t;

   state_t           state, state_n;
   logic [LEN_W-1:0] rem, rem_n;
   logic [3:0]       op_r, op_n;
   logic             eoi_r, eoi_n;
   logic             decrypt_n, hash_n, err_n, auth_ok_n, auth_done_n;

   logic [3:0]       ins_op;
   logic             ins_eoi;
   logic [LEN_W-1:0] ins_len;
   logic             ins_is_ld;
   logic             last;
   logic [1:0]       pad;
   logic [31:0]      shifted;
   logic             fire;

   // Map a load opcode onto the core's data type.
   function automatic logic [3:0] map_type(input logic [3:0] op);
      case (op)
         OP_LD_NONCE:        map_type = D_NONCE;
         OP_LD_AD:           map_type = D_AD;
         OP_LD_PT, OP_LD_CT: map_type = D_PTCT;
         OP_LD_TAG:          map_type = D_TAG;
         default:            map_type = D_NULL;
      endcase
   endfunction

   assign ins_op    = cmd[31:28];
   assign ins_eoi   = cmd[24];
   assign ins_len   = cmd[LEN_W-1:0];
   assign ins_is_ld = (ins_op >= OP_LD_KEY) && (ins_op <= OP_LD_TAG);
   assign last      = (rem <= LEN_W'(4));
   // Partial last word: valid bytes are left-aligned, pad = missing bytes.
   assign pad       = 2'(3'd4 - rem[2:0]);
   assign shifted   = cmd << {pad, 3'b000};

   // Output path is a pure pass-through, filtered by type.
   assign bdo_ready = out_ready;
   assign out_data  = bdo;
   assign out_type  = bdo_type;
   assign out_last  = bdo_eot;
   assign out_valid = bdo_valid &
                      ((bdo_type == D_PTCT) || (bdo_type == D_TAG) || (bdo_type == D_HASH));

   assign busy = (state != IDLE);

   // State and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         op_r      <= OP_DO_ENC;
         eoi_r     <= 1'b0;
         decrypt   <= 1'b0;
         hash      <= 1'b0;
         err       <= 1'b0;
         auth_ok   <= 1'b0;
         auth_done <= 1'b0;
      end else begin
         state     <= state_n;
         rem       <= rem_n;
         op_r      <= op_n;
         eoi_r     <= eoi_n;
         decrypt   <= decrypt_n;
         hash      <= hash_n;
         err       <= err_n;
         auth_ok   <= auth_ok_n;
         auth_done <= auth_done_n;
      end
   end

   // Next-state and core-side handshake logic.
   always_comb begin
      state_n         = state;
      rem_n           = rem;
      op_n            = op_r;
      eoi_n           = eoi_r;
      decrypt_n       = decrypt;
      hash_n          = hash;
      err_n           = err;
      auth_ok_n       = auth_ok;
      auth_done_n     = auth_done;
      cmd_ready       = 1'b0;
      key             = '0;
      key_valid       = 1'b0;
      bdi             = '0;
      bdi_valid       = 1'b0;
      bdi_type        = D_NULL;
      bdi_eot         = 1'b0;
      bdi_eoi         = 1'b0;
      bdi_valid_bytes = 4'h0;
      auth_ready      = 1'b0;
      fire            = 1'b0;

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               auth_done_n = 1'b0;
               if (ins_op == OP_DO_ENC) begin
                  decrypt_n = 1'b0;
                  hash_n    = 1'b0;
               end else if (ins_op == OP_DO_DEC) begin
                  decrypt_n = 1'b1;
                  hash_n    = 1'b0;
               end else if (ins_op == OP_DO_HASH) begin
                  decrypt_n = 1'b0;
                  hash_n    = 1'b1;
               end else if (ins_is_ld) begin
                  op_n  = ins_op;
                  eoi_n = ins_eoi;
                  if (ins_len != '0) begin
                     rem_n   = ins_len;
                     state_n = LOAD;
                  end else if (ins_eoi) begin
                     state_n = EMPTY;
                  end
               end else begin
                  err_n = 1'b1;
               end
            end
         end

         LOAD: begin
            bdi             = last ? CCW'(shifted) : CCW'(cmd);
            bdi_valid_bytes = last ? {rem >= LEN_W'(4), rem >= LEN_W'(3),
                                      rem >= LEN_W'(2), rem >= LEN_W'(1)} : 4'hF;
            bdi_eot         = last;
            bdi_eoi         = last & eoi_r;
            auth_ready      = (op_r == OP_LD_TAG);
            if (op_r == OP_LD_KEY) begin
               key       = CCSW'(cmd);
               key_valid = cmd_valid;
               cmd_ready = key_ready;
            end else begin
               bdi_valid = cmd_valid;
               cmd_ready = bdi_ready;
               bdi_type  = map_type(op_r);
            end
            fire = cmd_valid & cmd_ready;
            if (fire) begin
               rem_n = last ? '0 : rem - LEN_W'(4);
               if (last) state_n = IDLE;
            end
         end

         EMPTY: begin
            bdi_valid = 1'b1;
            bdi_eot   = 1'b1;
            bdi_eoi   = 1'b1;
            bdi_type  = hash ? D_AD : map_type(op_r);
            if (bdi_ready) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase

      if (auth_valid && auth_ready) begin
         auth_ok_n   = auth;
         auth_done_n = 1'b1;
      end

      // Reset aborts any load in progress: no beat may transfer this cycle.
      if (rst) begin
         cmd_ready  = 1'b0;
         key_valid  = 1'b0;
         bdi_valid  = 1'b0;
         auth_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_ascon_cmd_ctrl.sv
// Testbench for ascon_cmd_ctrl: table of single-word INS/DAT vectors with
// expected core-side outputs, plus directed multi-cycle sequences.
module tb_ascon_cmd_ctrl;

   localparam logic [3:0] D_NULL  = 4'h0;
   localparam logic [3:0] D_NONCE = 4'h1;
   localparam logic [3:0] D_AD    = 4'h2;
   localparam logic [3:0] D_PTCT  = 4'h3;
   localparam logic [3:0] D_HASH  = 4'h5;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cmd;
   logic        cmd_valid, cmd_ready;
   logic [31:0] key;
   logic        key_valid, key_ready;
   logic [31:0] bdi;
   logic        bdi_valid, bdi_ready;
   logic [3:0]  bdi_type;
   logic        bdi_eot, bdi_eoi;
   logic [3:0]  bdi_valid_bytes;
   logic        decrypt, hash;
   logic [31:0] bdo;
   logic [3:0]  bdo_type;
   logic        bdo_eot, bdo_valid, bdo_ready;
   logic [31:0] out_data;
   logic [3:0]  out_type;
   logic        out_last, out_valid, out_ready;
   logic        auth, auth_valid, auth_ready, auth_ok, auth_done;
   logic        busy, err;

   ascon_cmd_ctrl #(.LEN_W(24)) dut (
      .clk(clk), .rst(rst),
      .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .key(key), .key_valid(key_valid), .key_ready(key_ready),
      .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
      .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
      .bdi_valid_bytes(bdi_valid_bytes),
      .decrypt(decrypt), .hash(hash),
      .bdo(bdo), .bdo_type(bdo_type), .bdo_eot(bdo_eot),
      .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
      .out_data(out_data), .out_type(out_type), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready),
      .auth_ok(auth_ok), .auth_done(auth_done),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] cmd;
      logic        cr, kv, bv;
      logic [31:0] data;
      logic [3:0]  typ, mask;
      logic        eot, eoi;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic [31:0] c, input logic cr, input logic kv,
                               input logic bv, input logic [31:0] d, input logic [3:0] t,
                               input logic [3:0] m, input logic eot, input logic eoi);
      vec_t v;
      v.cmd = c; v.cr = cr; v.kv = kv; v.bv = bv; v.data = d;
      v.typ = t; v.mask = m; v.eot = eot; v.eoi = eoi;
      vq.push_back(v);
   endfunction

   function automatic void add_ins(input logic [31:0] c);
      add(c, 1'b1, 1'b0, 1'b0, 32'h0, D_NULL, 4'h0, 1'b0, 1'b0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_ins(input logic [31:0] c);
      cmd = c;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd = '0; cmd_valid = 1'b0; key_ready = 1'b1; bdi_ready = 1'b1;
      bdo = '0; bdo_type = D_NULL; bdo_eot = 1'b0; bdo_valid = 1'b0; out_ready = 1'b0;
      auth = 1'b0; auth_valid = 1'b0;

      // Vector table: one word per entry, all ready signals high.
      add_ins(32'h0000_0000);                                   // DO_ENC
      add_ins(32'h3000_0010);                                   // LD_KEY len16
      add(32'h0102_0304, 1, 1, 0, 32'h0102_0304, D_NULL, 4'hF, 0, 0);
      add(32'h0506_0708, 1, 1, 0, 32'h0506_0708, D_NULL, 4'hF, 0, 0);
      add(32'h090A_0B0C, 1, 1, 0, 32'h090A_0B0C, D_NULL, 4'hF, 0, 0);
      add(32'h0D0E_0F10, 1, 1, 0, 32'h0D0E_0F10, D_NULL, 4'hF, 1, 0);
      add_ins(32'h5000_0005);                                   // LD_AD len5
      add(32'h1122_3344, 1, 0, 1, 32'h1122_3344, D_AD, 4'hF, 0, 0);
      add(32'h0000_00AA, 1, 0, 1, 32'hAA00_0000, D_AD, 4'h1, 1, 0);
      add_ins(32'h4100_0010);                                   // LD_NONCE len16 eoi
      add(32'hC0C1_C2C3, 1, 0, 1, 32'hC0C1_C2C3, D_NONCE, 4'hF, 0, 0);
      add(32'hC4C5_C6C7, 1, 0, 1, 32'hC4C5_C6C7, D_NONCE, 4'hF, 0, 0);
      add(32'hC8C9_CACB, 1, 0, 1, 32'hC8C9_CACB, D_NONCE, 4'hF, 0, 0);
      add(32'hCCCD_CECF, 1, 0, 1, 32'hCCCD_CECF, D_NONCE, 4'hF, 1, 1);
      add_ins(32'h7100_0006);                                   // LD_CT len6 eoi
      add(32'hA1A2_A3A4, 1, 0, 1, 32'hA1A2_A3A4, D_PTCT, 4'hF, 0, 0);
      add(32'h0000_B1B2, 1, 0, 1, 32'hB1B2_0000, D_PTCT, 4'h3, 1, 1);
      add_ins(32'h5000_0000);                                   // LD_AD len0: no-op
      add_ins(32'h1000_0000);                                   // DO_DEC

      step(); step();
      rst = 1'b0;
      @(negedge clk);
      check("reset_state", 64'({busy, decrypt, hash, err, auth_ok, auth_done,
                                key_valid, bdi_valid, out_valid, cmd_ready}),
            64'(10'b0000000001));

      for (int i = 0; i < vq.size(); i++) begin
         cmd = vq[i].cmd;
         cmd_valid = 1'b1;
         @(negedge clk);
         check($sformatf("vec%0d", i),
               64'({cmd_ready, key_valid, bdi_valid, (vq[i].kv ? key : bdi),
                    bdi_type, bdi_valid_bytes, bdi_eot, bdi_eoi}),
               64'({vq[i].cr, vq[i].kv, vq[i].bv, vq[i].data,
                    vq[i].typ, vq[i].mask, vq[i].eot, vq[i].eoi}));
         if (i == 5) check("key_mode", 64'({decrypt, hash}), 64'(2'b00));
         step();
         cmd_valid = 1'b0;
      end
      @(negedge clk);
      check("dec_mode", 64'({decrypt, hash, busy}), 64'(3'b100));

      // LD_PT len3 eoi with core stalled for three cycles.
      step();
      send_ins(32'h6100_0003);
      cmd = 32'h00AB_CDEF; cmd_valid = 1'b1; bdi_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d", k), 64'({cmd_ready, bdi_valid, busy}), 64'(3'b011));
         step();
      end
      bdi_ready = 1'b1;
      @(negedge clk);
      check("pt_last", 64'({cmd_ready, bdi_valid, bdi, bdi_type, bdi_valid_bytes, bdi_eot, bdi_eoi}),
            64'({1'b1, 1'b1, 32'hABCD_EF00, D_PTCT, 4'h7, 1'b1, 1'b1}));
      step();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("pt_idle", 64'({busy, bdi_valid}), 64'(2'b00));

      // Hash with empty AD, then hash output beats.
      step();
      send_ins(32'h2000_0000);
      @(negedge clk);
      check("hash_mode", 64'({decrypt, hash}), 64'(2'b01));
      step();
      bdi_ready = 1'b0;
      send_ins(32'h5100_0000);
      @(negedge clk);
      check("empty_beat", 64'({cmd_ready, bdi_valid, bdi, bdi_type, bdi_valid_bytes, bdi_eot, bdi_eoi, busy}),
            64'({1'b0, 1'b1, 32'h0, D_AD, 4'h0, 1'b1, 1'b1, 1'b1}));
      step();
      @(negedge clk);
      check("empty_hold", 64'({bdi_valid, busy}), 64'(2'b11));
      step();
      bdi_ready = 1'b1;
      step();
      @(negedge clk);
      check("empty_done", 64'({bdi_valid, busy}), 64'(2'b00));
      bdo = 32'hCAFE_BABE; bdo_type = D_HASH; bdo_eot = 1'b1; bdo_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("out_hash", 64'({out_valid, out_data, out_type, out_last, bdo_ready}),
            64'({1'b1, 32'hCAFE_BABE, D_HASH, 1'b1, 1'b1}));
      bdo_type = D_AD; out_ready = 1'b0;
      #1;
      check("out_filter", 64'({out_valid, bdo_ready}), 64'(2'b00));
      bdo_valid = 1'b0;

      // Decrypt with tag load and auth result.
      step();
      send_ins(32'h1000_0000);
      send_ins(32'h8000_0010);
      cmd = 32'h7777_0000; cmd_valid = 1'b1; auth = 1'b1; auth_valid = 1'b1;
      @(negedge clk);
      check("auth_ready_tag", 64'({auth_ready, bdi_type}), 64'({1'b1, 4'h4}));
      step();
      auth_valid = 1'b0; auth = 1'b0;
      @(negedge clk);
      check("auth_latched", 64'({auth_ok, auth_done}), 64'(2'b11));
      for (int k = 0; k < 3; k++) step();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("auth_idle", 64'({auth_ready, busy, auth_done}), 64'(3'b001));
      step();
      send_ins(32'h0000_0000);
      @(negedge clk);
      check("auth_clear", 64'({auth_ok, auth_done}), 64'(2'b10));

      // Illegal opcode.
      step();
      send_ins(32'hF000_0000);
      @(negedge clk);
      check("illegal", 64'({err, busy}), 64'(2'b10));

      // Reset in the middle of a PT load.
      step();
      send_ins(32'h1000_0000);
      send_ins(32'h6000_0008);
      cmd = 32'h1234_5678; cmd_valid = 1'b1;
      step();
      rst = 1'b1;
      @(negedge clk);
      check("rst_gate", 64'({bdi_valid, cmd_ready}), 64'(2'b00));
      step();
      rst = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_abort", 64'({bdi_valid, busy, decrypt, err}), 64'(4'b0000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
